// File: rtl/panic_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : panic_ingress_arbiter
// Description : Packet-granular round-robin merge of PORTS AXIS sources into
//               one stream, with truncation of over-long packets.
// Revision    : 1.0 - initial release
// ============================================================================
module panic_ingress_arbiter #(
    parameter int PORTS           = 4,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int MAX_PKT_BEATS   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [PORTS-1:0]                   s_axis_tvalid,
    input  logic [PORTS-1:0]                   s_axis_tlast,
    input  logic [PORTS-1:0]                   s_axis_tuser,
    output logic [PORTS-1:0]                   s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    output logic                               m_axis_tuser,
    input  logic                               m_axis_tready,
    output logic [PORTS-1:0]                   grant_onehot,
    output logic [31:0]                        pkt_count,
    output logic [15:0]                        trunc_count
);

    localparam int               c_ptr_w       = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [15:0]      c_last_beat   = 16'(MAX_PKT_BEATS - 1);
    localparam logic [PORTS-1:0] c_onehot_base = PORTS'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_ptr_w-1:0]   rr_ptr_q, rr_ptr_d;
    logic [c_ptr_w-1:0]   grant_q, grant_d;
    logic [PORTS-1:0]     grant_onehot_q, grant_onehot_d;
    logic [15:0]          beat_q, beat_d;
    logic [31:0]          pkt_count_q, pkt_count_d;
    logic [15:0]          trunc_count_q, trunc_count_d;

    logic                        w_found;
    logic [c_ptr_w-1:0]          w_pick;
    logic [c_ptr_w-1:0]          w_next_ptr;
    logic [AXIS_DATA_WIDTH-1:0]  w_src_data;
    logic [AXIS_KEEP_WIDTH-1:0]  w_src_keep;
    logic                        w_src_valid;
    logic                        w_src_last;
    logic                        w_src_user;
    logic                        w_trunc_beat;

    // Lowest valid port overall, then overridden by the lowest valid port at
    // or above rr_ptr: together this is the first valid port scanning from rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = rr_ptr_q;
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (s_axis_tvalid[p]) begin
                w_found = 1'b1;
                w_pick  = c_ptr_w'(p);
            end
        end
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (s_axis_tvalid[p] && (c_ptr_w'(p) >= rr_ptr_q)) begin
                w_pick = c_ptr_w'(p);
            end
        end
    end

    always_comb begin
        w_src_data  = '0;
        w_src_keep  = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        w_src_user  = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (grant_q == c_ptr_w'(p)) begin
                w_src_data  = s_axis_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                w_src_keep  = s_axis_tkeep[p*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
                w_src_valid = s_axis_tvalid[p];
                w_src_last  = s_axis_tlast[p];
                w_src_user  = s_axis_tuser[p];
            end
        end
    end

    assign w_next_ptr   = (grant_q == c_ptr_w'(PORTS - 1)) ? '0 : grant_q + 1'b1;
    // A real tlast on the limit beat is a normal completion, not a truncation.
    assign w_trunc_beat = (beat_q == c_last_beat) && !w_src_last;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        grant_onehot_d = grant_onehot_q;
        beat_d         = beat_q;
        pkt_count_d    = pkt_count_q;
        trunc_count_d  = trunc_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d        = w_pick;
                    grant_onehot_d = c_onehot_base << w_pick;
                    beat_d         = '0;
                    state_d        = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_src_valid && m_axis_tready) begin
                    beat_d = beat_q + 16'd1;
                    if (w_src_last) begin
                        pkt_count_d    = pkt_count_q + 32'd1;
                        rr_ptr_d       = w_next_ptr;
                        grant_onehot_d = '0;
                        state_d        = ST_IDLE;
                    end else if (w_trunc_beat) begin
                        pkt_count_d = pkt_count_q + 32'd1;
                        if (trunc_count_q != 16'hFFFF) begin
                            trunc_count_d = trunc_count_q + 16'd1;
                        end
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_src_valid && w_src_last) begin
                    rr_ptr_d       = w_next_ptr;
                    grant_onehot_d = '0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            grant_onehot_q <= '0;
            beat_q         <= '0;
            pkt_count_q    <= '0;
            trunc_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            grant_onehot_q <= grant_onehot_d;
            beat_q         <= beat_d;
            pkt_count_q    <= pkt_count_d;
            trunc_count_q  <= trunc_count_d;
        end
    end

    // Handshake outputs are forced low while rst is high, even before the
    // state register has returned to idle.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        if (!rst) begin
            if (state_q == ST_XFER) begin
                m_axis_tdata  = w_src_data;
                m_axis_tkeep  = w_src_keep;
                m_axis_tvalid = w_src_valid;
                m_axis_tlast  = w_src_last | w_trunc_beat;
                m_axis_tuser  = w_src_user | w_trunc_beat;
            end
            for (int p = 0; p < PORTS; p++) begin
                if (grant_q == c_ptr_w'(p)) begin
                    s_axis_tready[p] = (state_q == ST_XFER)  ? m_axis_tready :
                                       (state_q == ST_DRAIN);
                end
            end
        end
    end

    assign grant_onehot = grant_onehot_q;
    assign pkt_count    = pkt_count_q;
    assign trunc_count  = trunc_count_q;

endmodule
`default_nettype wire
